vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Downstream stage of the horizontal/vertical pixel counters in the VGA path.
- Takes the raw H and V count values and produces registered hsync, vsync, video_on, pixel coordinates, line/frame strobes and a vertical-phase state.
- Feeds the pixel/colour generator and the monitor connector.
- Runs in the 25 MHz pixel clock domain; all outputs are registered.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch; H_TOTAL = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
- clk_25Mhz  input  1  pixel clock
- reset_n  input  1  synchronous active-low reset
- H_Count_Value  input  16  horizontal count from the horizontal counter
- V_Count_Value  input  16  vertical count from the vertical counter
- hsync  output  1  horizontal sync at SYNC_POL level when asserted
- vsync  output  1  vertical sync at SYNC_POL level when asserted
- video_on  output  1  high inside the visible region
- pixel_x  output  10  visible column, 0 when blanked
- pixel_y  output  10  visible row, 0 when blanked
- line_start  output  1  one-clock pulse at H count 0
- frame_start  output  1  one-clock pulse at H=0 and V=0
- v_phase  output  2  0 ACTIVE, 1 FP, 2 SYNC, 3 BP

Behaviour:
- Interface: one clock, clk_25Mhz; reset_n is synchronous, active-low, sampled on the rising edge of clk_25Mhz.
- Reset values (reset_n low at a clock edge):
  - hsync = vsync = ~SYNC_POL (deasserted)
  - video_on = 0; pixel_x = pixel_y = 0
  - line_start = frame_start = 0
  - v_phase = BP (3)
- Latency: every output reflects the counts sampled one clock earlier (one register stage).
- hsync asserted iff H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC, i.e. H in [656, 751].
- vsync asserted iff V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC, i.e. V in [490, 491].
- video_on = (H < H_ACTIVE) and (V < V_ACTIVE).
- pixel_x = H[9:0] and pixel_y = V[9:0] when video_on, else both 0.
- line_start = (H == 0); frame_start = (H == 0) and (V == 0).
- Out-of-range inputs (H >= H_TOTAL or V >= V_TOTAL, e.g. V = 525): the block treats them as blanking.
  - video_on = 0; the corresponding sync is deasserted; no strobes.
  - Compares use the full 16 bits; no truncation before compare.
- v_phase state machine updates only on clocks where H == 0:
  - V == 0 -> ACTIVE
  - V == V_ACTIVE (480) -> FP
  - V == V_ACTIVE+V_FP (490) -> SYNC
  - V == V_ACTIVE+V_FP+V_SYNC (492) -> BP
  - any other V, including V >= V_TOTAL -> hold
  - H != 0 -> hold
- Count jumps (e.g. the counter restarted mid-frame): outputs follow the new counts from the next clock. v_phase realigns at the next matching boundary line.
- Reset mid-frame: outputs take reset values on the next clock. Normal decode resumes on the first clock after reset_n returns high. v_phase stays BP until a boundary line is seen.
- Simultaneous events: frame_start implies line_start in the same clock. At H=0, V=0, v_phase -> ACTIVE in that same update.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - adds output frame_count[7:0], reset to 0
  - increments one clock after each frame_start pulse (registered from the frame_start condition)
  - wraps 255 -> 0
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: reset_n = 0 for 3 clocks with arbitrary counts -> hsync = vsync = 1, video_on = 0, pixel_x = pixel_y = 0, v_phase = 3, strobes = 0.
- Line sweep: V = 100, H 0..799 -> video_on high for H 0..639 one clock late; pixel_x tracks H; hsync low exactly for H 656..751; line_start single pulse after H = 0.
- Full frame: drive counts through V 0..525, H 0..799 each line -> vsync low only on lines 490..491; v_phase sequence 0 -> 1 at line 480 -> 2 at 490 -> 3 at 492 -> 0 at next V = 0; one frame_start per frame.
- Out of range: V = 525 for a whole line -> video_on = 0, vsync deasserted, no line_start, v_phase holds 3; H = 900 -> hsync deasserted, video_on = 0.
- Mid-frame reset: assert reset_n = 0 at V = 200, H = 300 for 1 clock -> next clock outputs at reset values; after release, pixel_x follows H, v_phase = 3 until V = 0 with H = 0 gives ACTIVE.
- VGA_FRAME_CNT_EN: run 257 frames -> frame_count reads 1 after frame 257, having wrapped 255 -> 0; without the macro, the build has no frame_count port.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Registered VGA sync decode: turns raw H/V counts into sync, blanking, coordinates and strobes.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk_25Mhz,
    input  logic        reset_n,
    input  logic [15:0] H_Count_Value,
    input  logic [15:0] V_Count_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [1:0]  v_phase
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_count
`endif
);

    localparam logic [15:0] H_VIS     = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_LO = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_HI = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_VIS     = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_LO = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_HI = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_TOTAL   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    phase_e      phase_q, phase_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        h_zero;

    always_comb begin
        h_zero     = (H_Count_Value == '0);
        hsync_d    = ~SYNC_POL;
        vsync_d    = ~SYNC_POL;
        video_on_d = 1'b0;
        pixel_x_d  = '0;
        pixel_y_d  = '0;

        // Full 16-bit compares, so out-of-range counts naturally fall into blanking.
        if ((H_Count_Value >= H_SYNC_LO) && (H_Count_Value < H_SYNC_HI))
            hsync_d = SYNC_POL;
        if ((V_Count_Value >= V_SYNC_LO) && (V_Count_Value < V_SYNC_HI))
            vsync_d = SYNC_POL;

        if ((H_Count_Value < H_VIS) && (V_Count_Value < V_VIS)) begin
            video_on_d = 1'b1;
            pixel_x_d  = H_Count_Value[9:0];
            pixel_y_d  = V_Count_Value[9:0];
        end

        line_start_d  = h_zero && (V_Count_Value < V_TOTAL);
        frame_start_d = h_zero && (V_Count_Value == '0);

        phase_d = phase_q;
        if (h_zero) begin
            if (V_Count_Value == '0)
                phase_d = PH_ACTIVE;
            else if (V_Count_Value == V_VIS)
                phase_d = PH_FP;
            else if (V_Count_Value == V_SYNC_LO)
                phase_d = PH_SYNC;
            else if (V_Count_Value == V_SYNC_HI)
                phase_d = PH_BP;
        end
    end

    always_ff @(posedge clk_25Mhz) begin
        if (!reset_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            phase_q       <= PH_BP;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            phase_q       <= phase_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign v_phase     = phase_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_count_q, frame_count_d;

    // Counts registered frame_start pulses, so it lands one clock after the strobe.
    always_comb begin
        frame_count_d = frame_count_q + {7'd0, frame_start_q};
    end

    always_ff @(posedge clk_25Mhz) begin
        if (!reset_n)
            frame_count_q <= '0;
        else
            frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen against a count-rule reference model.
// Define VGA_FRAME_CNT_EN to also exercise the frame counter.
module tb_vga_sync_gen;

    logic        clk;
    logic        rst_n;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        hsync, vsync, video_on, line_start, frame_start;
    logic [9:0]  pixel_x, pixel_y;
    logic [1:0]  v_phase;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]  frame_count;
`endif

    int checks = 0;
    int errors = 0;
    int m_phase = 3;

    vga_sync_gen dut (
        .clk_25Mhz     (clk),
        .reset_n       (rst_n),
        .H_Count_Value (h_cnt),
        .V_Count_Value (v_cnt),
        .hsync         (hsync),
        .vsync         (vsync),
        .video_on      (video_on),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .v_phase       (v_phase)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    logic [26:0] dut_vec;
    assign dut_vec = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, v_phase};

    // Vertical region a given line belongs to, from the 640x480 timing table.
    function automatic int region(int v);
        if (v < 480) return 0;
        if (v < 490) return 1;
        if (v < 492) return 2;
        return 3;
    endfunction

    // Expected registered outputs for counts (h,v) presented before the next edge.
    function automatic logic [26:0] model(int h, int v, bit rst);
        logic hs, vs, von, ls, fs;
        logic [9:0] px, py;
        if (rst) begin
            m_phase = 3;
            return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 2'd3};
        end
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
        von = (h < 640) && (v < 480);
        px  = von ? 10'(h) : 10'd0;
        py  = von ? 10'(v) : 10'd0;
        ls  = (h == 0) && (v < 525);
        fs  = (h == 0) && (v == 0);
        if (h == 0 && (v == 0 || v == 480 || v == 490 || v == 492))
            m_phase = region(v);
        return {hs, vs, von, px, py, ls, fs, 2'(m_phase)};
    endfunction

    task automatic apply(int h, int v, bit rst);
        @(negedge clk);
        h_cnt = 16'(h);
        v_cnt = 16'(v);
        rst_n = !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] exp;
        int h, v;
        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(0, 65535));
            v = int'($urandom_range(0, 65535));
            apply(h, v, 1'b1);
            exp = model(h, v, 1'b1);
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL reset h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp);
            end
        end
    endtask

    task automatic test_line_sweep();
        logic [26:0] exp;
        int v, ls_count;
        v = int'($urandom_range(0, 479));
        ls_count = 0;
        for (int h = 0; h < 800; h++) begin
            apply(h, v, 1'b0);
            exp = model(h, v, 1'b0);
            if (line_start === 1'b1) ls_count++;
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL line_sweep h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp);
            end
        end
        checks++;
        if (ls_count != 1) begin
            errors++;
            $display("FAIL line_start_count got=%0d exp=1", ls_count);
        end
    endtask

    task automatic test_full_frame();
        logic [26:0] exp;
        int h, fs_count;
        fs_count = 0;
        for (int v = 0; v <= 526; v++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0) h = 0;
                else if (k == 1) h = 656 + int'($urandom_range(0, 95));
                else h = int'($urandom_range(1, 799));
                apply(h, (v == 526) ? 0 : v, 1'b0);
                exp = model(h, (v == 526) ? 0 : v, 1'b0);
                if (frame_start === 1'b1) fs_count++;
                checks++;
                if (dut_vec !== exp) begin
                    errors++;
                    $display("FAIL full_frame h=%0d v=%0d got=%h exp=%h", h, v, dut_vec, exp);
                end
            end
        end
        checks++;
        if (fs_count != 2) begin
            errors++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_count);
        end
    endtask

    task automatic test_out_of_range();
        logic [26:0] exp;
        int v;
        apply(0, 492, 1'b0);
        void'(model(0, 492, 1'b0));
        for (int h = 0; h < 800; h++) begin
            apply(h, 525, 1'b0);
            exp = model(h, 525, 1'b0);
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL oor_v h=%0d v=525 got=%h exp=%h", h, dut_vec, exp);
            end
        end
        for (int i = 0; i < 20; i++) begin
            v = (i < 10) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 65535));
            apply(900 + i * 3000, v, 1'b0);
            exp = model(900 + i * 3000, v, 1'b0);
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL oor_h h=%0d v=%0d got=%h exp=%h", 900 + i * 3000, v, dut_vec, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [26:0] exp;
        apply(0, 0, 1'b0);
        void'(model(0, 0, 1'b0));
        apply(300, 200, 1'b1);
        exp = model(300, 200, 1'b1);
        checks++;
        if (dut_vec !== exp) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", dut_vec, exp);
        end
        for (int h = 301; h < 800; h += 37) begin
            apply(h, 200, 1'b0);
            exp = model(h, 200, 1'b0);
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL after_reset h=%0d got=%h exp=%h", h, dut_vec, exp);
            end
        end
        apply(0, 0, 1'b0);
        exp = model(0, 0, 1'b0);
        checks++;
        if (v_phase !== 2'd0 || dut_vec !== exp) begin
            errors++;
            $display("FAIL realign_active got=%h exp=%h", dut_vec, exp);
        end
    endtask

    task automatic test_random();
        logic [26:0] exp;
        int h, v;
        bit r;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: h = 0;
                1: h = 656 + int'($urandom_range(0, 1)) * 95 + int'($urandom_range(0, 1)) * (int'($urandom_range(0, 1)) ? -1 : 1);
                2: h = int'($urandom_range(800, 65535));
                default: h = int'($urandom_range(0, 799));
            endcase
            case ($urandom_range(0, 4))
                0: v = 0;
                1: v = 480 + 10 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 2));
                2: v = int'($urandom_range(525, 65535));
                default: v = int'($urandom_range(0, 524));
            endcase
            r = ($urandom_range(0, 49) == 0);
            apply(h, v, r);
            exp = model(h, v, r);
            checks++;
            if (dut_vec !== exp) begin
                errors++;
                $display("FAIL random h=%0d v=%0d rst=%0d got=%h exp=%h", h, v, r, dut_vec, exp);
            end
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_count();
        apply(10, 10, 1'b1);
        void'(model(10, 10, 1'b1));
        checks++;
        if (frame_count !== 8'd0) begin
            errors++;
            $display("FAIL frame_count_reset got=%0d exp=0", frame_count);
        end
        for (int f = 1; f <= 257; f++) begin
            apply(0, 0, 1'b0);
            apply(5, 0, 1'b0);
            checks++;
            if (frame_count !== 8'(f % 256)) begin
                errors++;
                $display("FAIL frame_count f=%0d got=%0d exp=%0d", f, frame_count, f % 256);
            end
        end
    endtask
`endif

    initial begin
        #10ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        h_cnt = '0;
        v_cnt = '0;
        test_reset();
        test_line_sweep();
        test_full_frame();
        test_out_of_range();
        test_mid_reset();
        test_random();
`ifdef VGA_FRAME_CNT_EN
        test_frame_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
